// File: rtl/div_ctrl_pkg.sv
// Shared definitions for the sequenced restoring divider controller.
//   state_t    : controller states (IDLE, CALC, FINISH)
//   DEF_N      : default operand width
//   DEF_OUT_W  : default result bus width
//   DIV0_QUOT  : quotient reported for a zero divisor (all ones)
//   REQ_ID0/1  : requester index values as reported on done_id
package div_ctrl_pkg;

  localparam int DEF_N     = 4;
  localparam int DEF_OUT_W = 8;

  localparam logic [DEF_OUT_W-1:0] DIV0_QUOT = '1;

  localparam logic REQ_ID0 = 1'b0;
  localparam logic REQ_ID1 = 1'b1;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    CALC   = 2'd1,
    FINISH = 2'd2
  } state_t;

endpackage

// File: rtl/div_step.sv
// One combinational restoring-division iteration.
//   i_a : partial remainder, N+1 bits (top bit is always 0 between steps)
//   i_q : dividend/quotient shift register
//   i_m : divisor
//   o_a : next partial remainder
//   o_q : next quotient shift register, new quotient bit in o_q[0]
module div_step #(
  parameter int N = 4
) (
  input  logic [N:0]   i_a,
  input  logic [N-1:0] i_q,
  input  logic [N-1:0] i_m,
  output logic [N:0]   o_a,
  output logic [N-1:0] o_q
);

  logic [N:0] w_shift;
  logic [N:0] w_diff;
  logic       w_unused_a_msb;

  // After every restore the remainder is below M, so i_a[N] never carries
  // information into the shift; the extra bit only absorbs the borrow.
  assign w_unused_a_msb = i_a[N];

  assign w_shift = {i_a[N-1:0], i_q[N-1]};
  assign w_diff  = w_shift - {1'b0, i_m};

  always_comb begin
    if (w_diff[N]) begin
      o_a = w_diff + {1'b0, i_m};
      o_q = {i_q[N-2:0], 1'b0};
    end else begin
      o_a = w_diff;
      o_q = {i_q[N-2:0], 1'b1};
    end
  end

endmodule

// File: rtl/div_seq_ctrl.sv
// Round-robin shared restoring divider, one quotient bit per clock.
//   clk, rst              : clock, synchronous active-high reset
//   req0/1                : operation requests, held until granted
//   dividend0/1, divisor0/1 : operands, captured on the grant edge
//   gnt                   : one-hot accept pulse (combinational, IDLE only)
//   busy                  : controller not idle
//   done, done_id         : one-cycle result pulse and owning requester
//   quotient, remainder   : zero-extended results, held until next done
//   div_zero              : current result came from a zero divisor
//
// state  | meaning
// IDLE   | arbitrate; a grant latches operands
// CALC   | one restoring step per cycle, N cycles
// FINISH | done pulse; results already registered
module div_seq_ctrl
  import div_ctrl_pkg::*;
#(
  parameter int N     = DEF_N,
  parameter int OUT_W = DEF_OUT_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req0,
  input  logic [N-1:0]     dividend0,
  input  logic [N-1:0]     divisor0,
  input  logic             req1,
  input  logic [N-1:0]     dividend1,
  input  logic [N-1:0]     divisor1,
  output logic [1:0]       gnt,
  output logic             busy,
  output logic             done,
  output logic             done_id,
  output logic [OUT_W-1:0] quotient,
  output logic [OUT_W-1:0] remainder,
  output logic             div_zero
);

  localparam int CNT_W = (N > 1) ? $clog2(N) : 1;

  state_t r_state;
  state_t w_state_next;

  logic             r_ptr;
  logic             r_id;
  logic [N:0]       r_a;
  logic [N-1:0]     r_q;
  logic [N-1:0]     r_m;
  logic [CNT_W-1:0] r_cnt;

  logic             r_done_id;
  logic [OUT_W-1:0] r_quot;
  logic [OUT_W-1:0] r_rem;
  logic             r_dz;

  logic [1:0]       w_gnt;
  logic             w_sel_id;
  logic [N-1:0]     w_sel_dvd;
  logic [N-1:0]     w_sel_dvs;
  logic             w_last_step;
  logic [N:0]       w_a_next;
  logic [N-1:0]     w_q_next;

  div_step #(.N(N)) u_step (
    .i_a (r_a),
    .i_q (r_q),
    .i_m (r_m),
    .o_a (w_a_next),
    .o_q (w_q_next)
  );

  assign w_sel_id    = w_gnt[1] ? REQ_ID1 : REQ_ID0;
  assign w_sel_dvd   = w_gnt[1] ? dividend1 : dividend0;
  assign w_sel_dvs   = w_gnt[1] ? divisor1 : divisor0;
  assign w_last_step = (r_cnt == CNT_W'(N - 1));

  always_comb begin
    w_gnt        = 2'b00;
    w_state_next = r_state;
    case (r_state)
      IDLE: begin
        // r_ptr names the requester favoured when both are asking.
        if (req0 && req1) begin
          w_gnt = (r_ptr == REQ_ID1) ? 2'b10 : 2'b01;
        end else if (req0) begin
          w_gnt = 2'b01;
        end else if (req1) begin
          w_gnt = 2'b10;
        end
        if (w_gnt != 2'b00) begin
          w_state_next = (w_sel_dvs == '0) ? FINISH : CALC;
        end
      end
      CALC: begin
        if (w_last_step) begin
          w_state_next = FINISH;
        end
      end
      FINISH: begin
        w_state_next = IDLE;
      end
      default: begin
        w_state_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= IDLE;
      r_ptr     <= REQ_ID0;
      r_id      <= REQ_ID0;
      r_a       <= '0;
      r_q       <= '0;
      r_m       <= '0;
      r_cnt     <= '0;
      r_done_id <= 1'b0;
      r_quot    <= '0;
      r_rem     <= '0;
      r_dz      <= 1'b0;
    end else begin
      r_state <= w_state_next;
      case (r_state)
        IDLE: begin
          if (w_gnt != 2'b00) begin
            r_ptr <= ~w_sel_id;
            r_id  <= w_sel_id;
            r_m   <= w_sel_dvs;
            r_a   <= '0;
            r_q   <= w_sel_dvd;
            r_cnt <= '0;
            // A zero divisor skips CALC, so its result is registered here
            // on the same edge that moves to FINISH.
            if (w_sel_dvs == '0) begin
              r_quot    <= '1;
              r_rem     <= '0;
              r_dz      <= 1'b1;
              r_done_id <= w_sel_id;
            end
          end
        end
        CALC: begin
          r_a   <= w_a_next;
          r_q   <= w_q_next;
          r_cnt <= r_cnt + 1'b1;
          if (w_last_step) begin
            r_quot    <= {{(OUT_W-N){1'b0}}, w_q_next};
            r_rem     <= {{(OUT_W-N){1'b0}}, w_a_next[N-1:0]};
            r_dz      <= 1'b0;
            r_done_id <= r_id;
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign gnt       = w_gnt;
  assign busy      = (r_state != IDLE);
  assign done      = (r_state == FINISH);
  assign done_id   = r_done_id;
  assign quotient  = r_quot;
  assign remainder = r_rem;
  assign div_zero  = r_dz;

endmodule

// File: tb/tb_div_seq_ctrl.sv
module tb_div_seq_ctrl;

  localparam int N = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic       req0, req1;
  logic [3:0] dividend0, divisor0, dividend1, divisor1;
  logic [1:0] gnt;
  logic       busy, done, done_id, div_zero;
  logic [7:0] quotient, remainder;

  int   n_chk  = 0;
  int   n_pass = 0;
  int   tb_ptr = 0;
  bit   have_prev = 0;
  logic [7:0] prev_q, prev_r;

  div_seq_ctrl #(.N(4), .OUT_W(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .req0      (req0),
    .dividend0 (dividend0),
    .divisor0  (divisor0),
    .req1      (req1),
    .dividend1 (dividend1),
    .divisor1  (divisor1),
    .gnt       (gnt),
    .busy      (busy),
    .done      (done),
    .done_id   (done_id),
    .quotient  (quotient),
    .remainder (remainder),
    .div_zero  (div_zero)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  function automatic int pick();
    if (req0 && req1) return tb_ptr;
    else if (req0) return 0;
    else return 1;
  endfunction

  // Entered just before the negedge of an IDLE cycle with requester exp_id
  // due to win. Leaves at the negedge of the done cycle.
  task automatic serve(input int exp_id, input bit glitch);
    logic [1:0] exp_gnt;
    logic [3:0] a, b;
    logic [7:0] eq, er;
    logic       ez;
    int         lat;
    exp_gnt = (exp_id == 1) ? 2'b10 : 2'b01;
    @(negedge clk);
    if (have_prev) begin
      check("hold_q", 32'(quotient), 32'(prev_q));
      check("hold_r", 32'(remainder), 32'(prev_r));
    end
    check("gnt", 32'(gnt), 32'(exp_gnt));
    check("idle_busy", 32'(busy), 0);
    check("idle_done", 32'(done), 0);
    a = (exp_id == 1) ? dividend1 : dividend0;
    b = (exp_id == 1) ? divisor1 : divisor0;
    if (b == 0) begin
      eq = 8'hFF; er = 8'h00; ez = 1'b1; lat = 1;
    end else begin
      eq = 8'(a / b); er = 8'(a % b); ez = 1'b0; lat = N + 1;
    end
    tb_ptr = (exp_id == 0) ? 1 : 0;
    @(posedge clk);
    #1;
    if (exp_id == 0) begin
      req0 = 1'b0; dividend0 = 4'($urandom_range(0, 15)); divisor0 = 4'($urandom_range(0, 15));
    end else begin
      req1 = 1'b0; dividend1 = 4'($urandom_range(0, 15)); divisor1 = 4'($urandom_range(0, 15));
    end
    for (int c = 1; c <= lat; c++) begin
      @(negedge clk);
      check("busy", 32'(busy), 1);
      check("gnt_busy", 32'(gnt), 0);
      if (c < lat) begin
        check("early_done", 32'(done), 0);
      end else begin
        check("done", 32'(done), 1);
        check("quot", 32'(quotient), 32'(eq));
        check("rem", 32'(remainder), 32'(er));
        check("dz", 32'(div_zero), 32'(ez));
        check("done_id", 32'(done_id), exp_id);
      end
      if (glitch && c == 2) req1 = 1'b1;
      if (glitch && c == 3) req1 = 1'b0;
    end
    prev_q = eq;
    prev_r = er;
    have_prev = 1;
  endtask

  task automatic launch(input bit r0, input bit r1, input logic [3:0] a0, input logic [3:0] b0,
                        input logic [3:0] a1, input logic [3:0] b1);
    @(posedge clk);
    #1;
    req0 = r0; dividend0 = a0; divisor0 = b0;
    req1 = r1; dividend1 = a1; divisor1 = b1;
  endtask

  task automatic drain();
    for (int k = 0; k < 2; k++) begin
      if (req0 || req1) serve(pick(), 1'b0);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bit         r0, r1;
    logic [3:0] a0, b0, a1, b1;
    rst = 1'b1;
    req0 = 1'b0; req1 = 1'b0;
    dividend0 = '0; divisor0 = '0; dividend1 = '0; divisor1 = '0;
    repeat (2) @(negedge clk);
    check("rst_gnt", 32'(gnt), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_done", 32'(done), 0);
    check("rst_q", 32'(quotient), 0);
    check("rst_r", 32'(remainder), 0);
    check("rst_dz", 32'(div_zero), 0);
    check("rst_id", 32'(done_id), 0);
    @(posedge clk);
    #1 rst = 1'b0;

    launch(1, 0, 13, 3, 0, 0);  drain();
    launch(1, 0, 15, 9, 0, 0);  drain();
    launch(0, 1, 0, 0, 7, 0);   drain();
    launch(1, 1, 12, 4, 9, 2);  drain();
    launch(1, 1, 5, 2, 6, 3);   drain();
    launch(1, 0, 0, 5, 0, 0);   drain();
    launch(1, 0, 15, 1, 0, 0);  drain();

    // requester 1 pulses while the divider is busy and never gets a grant
    launch(1, 0, 9, 4, 0, 0);
    serve(0, 1'b1);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check("drop_gnt", 32'(gnt), 0);
      check("drop_done", 32'(done), 0);
      check("drop_busy", 32'(busy), 0);
    end

    // reset during the second CALC cycle
    launch(1, 0, 14, 5, 0, 0);
    @(negedge clk);
    check("pre_rst_gnt", 32'(gnt), 1);
    @(posedge clk);
    #1;
    @(negedge clk);
    check("pre_rst_done1", 32'(done), 0);
    @(posedge clk);
    #1 rst = 1'b1;
    @(negedge clk);
    check("pre_rst_done2", 32'(done), 0);
    @(posedge clk);
    #1 rst = 1'b0;
    #2;
    check("abort_done", 32'(done), 0);
    check("abort_busy", 32'(busy), 0);
    check("abort_q", 32'(quotient), 0);
    check("abort_r", 32'(remainder), 0);
    check("abort_dz", 32'(div_zero), 0);
    check("abort_id", 32'(done_id), 0);
    tb_ptr = 0;
    prev_q = 8'h00;
    prev_r = 8'h00;
    have_prev = 1;
    serve(0, 1'b0);

    for (int it = 0; it < 40; it++) begin
      r0 = 1'($urandom_range(0, 1));
      r1 = 1'($urandom_range(0, 1));
      if (!r0 && !r1) r0 = 1'b1;
      a0 = 4'($urandom_range(0, 15));
      a1 = 4'($urandom_range(0, 15));
      b0 = ($urandom_range(0, 5) == 0) ? 4'd0 : 4'($urandom_range(1, 15));
      b1 = ($urandom_range(0, 5) == 0) ? 4'd0 : 4'($urandom_range(1, 15));
      launch(r0, r1, a0, b0, a1, b1);
      drain();
    end

    @(negedge clk);
    check("end_done", 32'(done), 0);
    check("end_busy", 32'(busy), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/div_seq_ctrl.md
Name: div_seq_ctrl

Overview:
- Multi-cycle controller that sequences an unsigned restoring-division datapath, one quotient bit per clock.
- Shares the single divider between two requesters (calculator keypad/ALU path = 0, secondary op source = 1) with round-robin arbitration.
- Returns zero-extended quotient/remainder with a one-cycle done pulse, matching the calculator's 8-bit result buses.

Parameters:
N, 4, operand width (dividend and divisor)
OUT_W, 8, result width; results zero-extended from N bits

Ports:
clk  in  1  system clock
rst  in  1  synchronous, active-high reset
req0  in  1  requester 0 operation request; held until gnt[0]
dividend0  in  N  requester 0 dividend
divisor0  in  N  requester 0 divisor
req1  in  1  requester 1 operation request; held until gnt[1]
dividend1  in  N  requester 1 dividend
divisor1  in  N  requester 1 divisor
gnt  out  2  one-hot accept pulse; operands captured on this cycle's edge
busy  out  1  high whenever state != IDLE
done  out  1  one-cycle result-valid pulse
done_id  out  1  requester index the result belongs to
quotient  out  OUT_W  result quotient, held until next done
remainder  out  OUT_W  result remainder, held until next done
div_zero  out  1  divisor was zero for the current result, held with result

Behaviour:
- Clock/reset: single clock clk; reset rst is synchronous, active-high.
- Reset values: gnt=0, busy=0, done=0, done_id=0, quotient=0, remainder=0, div_zero=0, state=IDLE, rr pointer=0 (requester 0 has priority).
- FSM states: IDLE, CALC, FINISH.
- IDLE:
  - gnt is combinational: state==IDLE and req asserted, selected by round robin.
  - If both requests are asserted, grant the requester the pointer favours.
  - After a grant to k, the pointer moves to favour the other requester.
  - On the grant edge, latch operands and the id.
  - Divisor==0 -> FINISH with div-zero result.
  - Otherwise: A=0 (N+1 bits), Q=dividend, step count=0 -> CALC.
- CALC, one step per cycle:
  - A' = {A[N-1:0], Q[N-1]} - {0, M} in N+1 bits; Q shifts left.
  - If A'[N]==1: restore A'+M and set Q[0]=0; else set Q[0]=1.
  - After N steps, register the results and go to FINISH.
- Width rule: the partial remainder is N+1 bits, so results are correct for every divisor, including M >= 2^(N-1).
- FINISH:
  - done=1 for exactly this cycle; quotient={0,Q}, remainder={0,A[N-1:0]}, div_zero=0.
  - Next state IDLE. No grant is issued in FINISH.
- Divide-by-zero: quotient=all ones (8'hFF), remainder=0, div_zero=1.
- Latency, grant in cycle 0:
  - Normal operation: CALC in cycles 1..N, done in cycle N+1 (cycle 5 for N=4).
  - Divide-by-zero: done in cycle 1.
  - Back-to-back: the earliest next grant is cycle N+2.
- Request dropped before grant: no effect, nothing latched. Operand changes after grant: ignored.
- Result outputs change only on the edge that raises done.
- Reset mid-operation:
  - Abort immediately to IDLE with all outputs at reset values; no done for the aborted op.
  - A requester still holding req is re-arbitrated from pointer=0.
- gnt, done and busy=0 are never simultaneously asserted with a grant in non-IDLE states.

Decomposition:
- Package div_ctrl_pkg holds:
  - state enum {IDLE, CALC, FINISH}
  - default N=4 and OUT_W=8
  - DIV0_QUOT constant (all ones)
  - requester index constants
- Sub-module div_step: one combinational restoring iteration.
  - Inputs: A (N+1 bits), Q, M.
  - Outputs: next A, next Q.
  - Instantiated once and registered by the controller.

Test Plan:
- req0 13/3 after reset -> gnt=2'b01 in cycle 0, done in cycle 5, quotient=8'h04, remainder=8'h01, done_id=0, div_zero=0, busy high cycles 1..5.
- req0 15/9 -> quotient=8'h01, remainder=8'h06; checks the N+1-bit remainder with divisor >= 8.
- req1 7/0 -> gnt=2'b10, done in cycle 1, quotient=8'hFF, remainder=8'h00, div_zero=1, done_id=1.
- Both requests held: req0 12/4, req1 9/2 -> sequence:
  - grant 0 first, then done q=3 r=0 id=0.
  - grant 1 at cycle 6, then done q=4 r=1 id=1.
  - Re-raise both: grant goes to 0.
- rst pulsed during the 2nd CALC cycle of 14/5 -> no done pulse; all outputs 0 and busy=0 the next cycle; held req0 re-granted, then q=2 r=4.
- Edge operands: 0/5 -> q=0 r=0; 15/1 -> q=8'h0F r=0; a request dropped before its grant -> no gnt, no done.
